shiftreg_seq: RTL and testbench
===============================

Name: shiftreg_seq

Overview:
Command-driven sequencer for the team's WIDTH-bit parallel-load shift register (shiftreg). Accepts one command per valid/ready handshake: parallel load value, shift count, fill bit. Drives the register's load_en/shift_en/load/shift_in pins, counts shift cycles, then captures regout and pulses done. Sits between a host/CPU-side command source and a shiftreg instance.

Parameters:
WIDTH, 4, width of the controlled shift register and of cmd_data/result
CNT_W, 3, width of cmd_nshift and the internal shift counter; must hold WIDTH

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_data  input  WIDTH  value to parallel-load
cmd_nshift  input  CNT_W  number of shift cycles requested
cmd_fill  input  1  bit driven on sr_shift_in during every shift cycle
sr_load_en  output  1  to shiftreg load_en
sr_load  output  WIDTH  to shiftreg load
sr_shift_en  output  1  to shiftreg shift_en
sr_shift_in  output  1  to shiftreg shift_in
sr_regout  input  WIDTH  from shiftreg regout
result  output  WIDTH  captured sr_regout at end of command
done  output  1  one-cycle pulse when result is updated
busy  output  1  high in every non-IDLE state

Behaviour:
- Clock clk, reset rst: one clock; reset is synchronous and active-high.
- Reset (any state, mid-command included): state<=IDLE, result<=0, done<=0, counter<=0, latched command<=0. Combinational outputs sr_load_en, sr_shift_en, sr_shift_in, sr_load all 0; cmd_ready=0 while rst is high.
- States: IDLE, LOAD, SHIFT, CAPTURE. sr_* outputs decoded from the state register only.
- IDLE: cmd_ready=1, busy=0. On cmd_valid&&cmd_ready at edge E0: latch cmd_data, cmd_fill, nshift_eff=min(cmd_nshift,WIDTH); go to LOAD.
- LOAD (one cycle): sr_load_en=1, sr_load=latched data, sr_shift_en=0. Next: SHIFT if nshift_eff>0, else CAPTURE. Counter<=nshift_eff.
- SHIFT: sr_shift_en=1, sr_shift_in=latched fill, sr_load_en=0. Counter decrements each edge; leave to CAPTURE on the edge where counter==1. Exactly nshift_eff consecutive shift_en cycles.
- CAPTURE (one cycle): all sr_* enables 0; at edge result<=sr_regout, done<=1, state<=IDLE.
- done is registered: high exactly the cycle after CAPTURE, coincident with cmd_ready=1; deasserts next cycle unless another CAPTURE.
- Latency: done high nshift_eff+2 cycles after E0. Back-to-back command accepted in the done cycle; no idle gap required.
- sr_load_en and sr_shift_en never both high.
- cmd_data/cmd_nshift/cmd_fill changes while busy: ignored.
- cmd_nshift > WIDTH: clamped to WIDTH, no error.
- result holds until the next CAPTURE or reset.

Optional Feature:
Macro SHIFTREG_SEQ_ABORT_EN.
- Defined: extra input abort (1) and output aborted (1). abort high in LOAD or SHIFT at an edge -> state<=IDLE, no CAPTURE, result unchanged, done not pulsed, aborted pulses one cycle (registered). abort in IDLE/CAPTURE ignored. rst has priority over abort.
- Undefined: ports absent; commands always run to completion.

Decomposition:
- Package shiftreg_seq_pkg: state encoding constants (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, CAPTURE=2'd3).
- No sub-module required; bench instantiates shiftreg_seq plus a WIDTH=4 shiftreg connected through the sr_* ports.

Test Plan:
- Reset: rst high 2 cycles in any state -> result=0000, done=0, cmd_ready=0 during rst, 1 the cycle after; all sr_* enables 0.
- Load only: data=1010, nshift=0 -> one sr_load_en cycle, zero shift_en cycles, result=1010, done 2 cycles after accept.
- Fill ones: data=1010, nshift=4, fill=1 -> exactly 4 shift_en cycles with shift_in=1, result=1111, done 6 cycles after accept.
- Clamp: data=0110, nshift=7, fill=0 -> exactly 4 shift_en cycles, result=0000.
- Back-to-back: cmd_valid held high with two commands (1010/n=0, 0101/n=0) -> second accepted in first done cycle; done pulses twice, results 1010 then 0101.
- Reset mid-SHIFT (data=1010, n=4, rst in 2nd shift cycle) -> IDLE next cycle, no done, result=0000; with SHIFTREG_SEQ_ABORT_EN, abort in same position -> aborted pulse, no done, previous result held.

Source files
------------

// File: rtl/shiftreg_seq_pkg.sv
// ============================================================================
// shiftreg_seq_pkg : state encoding shared by the shift-register sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package shiftreg_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      SHIFT   = 2'd2,
      CAPTURE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/shiftreg_seq.sv
// ============================================================================
// shiftreg_seq : command sequencer driving a parallel-load shift register.
// Optional abort port pair enabled by SHIFTREG_SEQ_ABORT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shiftreg_seq
   import shiftreg_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_nshift,
   input  logic             cmd_fill,
`ifdef SHIFTREG_SEQ_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             sr_load_en,
   output logic [WIDTH-1:0] sr_load,
   output logic             sr_shift_en,
   output logic             sr_shift_in,
   input  logic [WIDTH-1:0] sr_regout,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy
);

   localparam logic [CNT_W-1:0] C_MAX_SHIFT = CNT_W'(WIDTH);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_data;
   logic             r_fill;
   logic [CNT_W-1:0] r_nshift;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_done;
   logic [CNT_W-1:0] w_nshift_eff;
   logic             w_abort;

`ifdef SHIFTREG_SEQ_ABORT_EN
   logic r_aborted;
   assign w_abort = abort && ((r_state == LOAD) || (r_state == SHIFT));
   assign aborted = r_aborted;
`else
   assign w_abort = 1'b0;
`endif

   assign w_nshift_eff = (cmd_nshift > C_MAX_SHIFT) ? C_MAX_SHIFT : cmd_nshift;

   assign cmd_ready   = (r_state == IDLE) && !rst;
   assign busy        = (r_state != IDLE);
   assign sr_load_en  = (r_state == LOAD);
   assign sr_load     = (r_state == LOAD) ? r_data : '0;
   assign sr_shift_en = (r_state == SHIFT);
   assign sr_shift_in = (r_state == SHIFT) ? r_fill : 1'b0;
   assign result      = r_result;
   assign done        = r_done;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (cmd_valid) w_state_next = LOAD;
         LOAD:    w_state_next = (r_nshift != '0) ? SHIFT : CAPTURE;
         SHIFT:   if (r_cnt == CNT_W'(1)) w_state_next = CAPTURE;
         CAPTURE: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (w_abort) w_state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_data   <= '0;
         r_fill   <= 1'b0;
         r_nshift <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_data   <= cmd_data;
                  r_fill   <= cmd_fill;
                  r_nshift <= w_nshift_eff;
               end
            end
            LOAD:  r_cnt <= r_nshift;
            SHIFT: r_cnt <= r_cnt - CNT_W'(1);
            CAPTURE: begin
               r_result <= sr_regout;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SHIFTREG_SEQ_ABORT_EN
   always_ff @(posedge clk) begin
      if (rst) r_aborted <= 1'b0;
      else     r_aborted <= w_abort;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_shiftreg_seq.sv
// ============================================================================
// tb_shiftreg_seq : self-checking bench for shiftreg_seq with a 4-bit shiftreg
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shiftreg_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_data = 4'h0;
   logic [2:0] cmd_nshift = 3'd0;
   logic       cmd_fill = 1'b0;
   logic       sr_load_en, sr_shift_en, sr_shift_in;
   logic [3:0] sr_load, sr_regout, result;
   logic       done, busy;
`ifdef SHIFTREG_SEQ_ABORT_EN
   logic       abort = 1'b0;
   logic       aborted;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   shiftreg_seq #(.WIDTH(4), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_data   (cmd_data),
      .cmd_nshift (cmd_nshift),
      .cmd_fill   (cmd_fill),
`ifdef SHIFTREG_SEQ_ABORT_EN
      .abort      (abort),
      .aborted    (aborted),
`endif
      .sr_load_en (sr_load_en),
      .sr_load    (sr_load),
      .sr_shift_en(sr_shift_en),
      .sr_shift_in(sr_shift_in),
      .sr_regout  (sr_regout),
      .result     (result),
      .done       (done),
      .busy       (busy)
   );

   // Controlled 4-bit shift register: load wins, shift moves toward the MSB.
   logic [3:0] sr_q = 4'h0;
   always @(posedge clk) begin
      if (sr_load_en)       sr_q <= sr_load;
      else if (sr_shift_en) sr_q <= {sr_q[2:0], sr_shift_in};
   end
   assign sr_regout = sr_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction-level model: one command occupies cycles acc..acc+n+1,
   // the result appears with done in cycle acc+n+2.
   bit         m_active = 0;
   int         m_acc = 0, m_n = 0;
   logic [3:0] m_data = 0, m_result = 0, m_exp = 0;
   bit         m_fill = 0, exp_done = 0, exp_aborted = 0;

   always @(posedge clk) begin
      bit was_active;
      cyc++;
      exp_done    = 0;
      exp_aborted = 0;
      if (rst) begin
         m_active = 0;
         m_result = 4'h0;
      end else begin
         was_active = m_active;
         if (m_active && cyc == m_acc + m_n + 2) begin
            m_active = 0;
            m_result = m_exp;
            exp_done = 1;
         end
`ifdef SHIFTREG_SEQ_ABORT_EN
         else if (m_active && abort) begin
            m_active    = 0;
            exp_aborted = 1;
         end
`endif
         if (!was_active && cmd_valid) begin
            m_active = 1;
            m_acc    = cyc;
            m_n      = (int'(cmd_nshift) > 4) ? 4 : int'(cmd_nshift);
            m_data   = cmd_data;
            m_fill   = cmd_fill;
            m_exp    = 4'((int'(cmd_data) << m_n) | (cmd_fill ? ((1 << m_n) - 1) : 0));
         end
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         bit e_load, e_shift;
         e_load  = m_active && (cyc == m_acc);
         e_shift = m_active && (cyc > m_acc) && (cyc <= m_acc + m_n);
         check("cmd_ready", cmd_ready, !rst && !m_active);
         check("busy", busy, m_active);
         check("done", done, exp_done);
         check("result", result, m_result);
         check("sr_load_en", sr_load_en, e_load);
         check("sr_load", sr_load, e_load ? m_data : 4'h0);
         check("sr_shift_en", sr_shift_en, e_shift);
         check("sr_shift_in", sr_shift_in, e_shift ? m_fill : 1'b0);
         check("en_exclusive", sr_load_en & sr_shift_en, 1'b0);
`ifdef SHIFTREG_SEQ_ABORT_EN
         check("aborted", aborted, exp_aborted);
`endif
      end
   end

   // Issue one command, wait for done, pin result and latency to literals.
   task automatic run_cmd(input logic [3:0] d, input logic [2:0] n, input logic f,
                          input logic [3:0] exp_res, input int exp_lat);
      int t, acc;
      @(posedge clk); #2;
      cmd_valid = 1'b1; cmd_data = d; cmd_nshift = n; cmd_fill = f;
      t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #2;
      acc = cyc;
      cmd_valid = 1'b0; cmd_data = ~d; cmd_nshift = 3'd5; cmd_fill = ~f;
      t = 0;
      @(negedge clk);
      while (!done && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("done_timeout", 0, 1);
      else begin
         check("latency", cyc - acc, exp_lat);
         check("result_lit", result, exp_res);
      end
   endtask

   initial begin
      int acc1, acc2, t;
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc1, acc2, t;
      // Reset held two cycles.
      repeat (2) begin
         @(negedge clk);
         check("ready_in_rst", cmd_ready, 1'b0);
      end
      @(posedge clk); #2; rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", cmd_ready, 1'b1);
      check("result_rst", result, 4'h0);
      check("done_rst", done, 1'b0);
      check("en_rst", {sr_load_en, sr_shift_en}, 2'b00);

      run_cmd(4'b1010, 3'd0, 1'b0, 4'b1010, 2);   // load only
      run_cmd(4'b1010, 3'd4, 1'b1, 4'b1111, 6);   // fill ones
      run_cmd(4'b0110, 3'd7, 1'b0, 4'b0000, 6);   // clamp to 4
      run_cmd(4'b1010, 3'd2, 1'b1, 4'b1011, 4);   // partial shift

      // Back-to-back with cmd_valid held.
      @(posedge clk); #2;
      cmd_valid = 1'b1; cmd_data = 4'b1010; cmd_nshift = 3'd0; cmd_fill = 1'b0;
      @(negedge clk);
      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #2;
      acc1 = cyc;
      cmd_data = 4'b0101;
      t = 0;
      @(negedge clk);
      while (!done && t < 50) begin @(negedge clk); t++; end
      check("b2b_lat1", cyc - acc1, 2);
      check("b2b_res1", result, 4'b1010);
      check("b2b_ready_in_done", cmd_ready, 1'b1);
      @(posedge clk); #2;
      acc2 = cyc;
      cmd_valid = 1'b0;
      check("b2b_accept_gap", acc2 - acc1, 3);
      t = 0;
      @(negedge clk);
      while (!done && t < 50) begin @(negedge clk); t++; end
      check("b2b_lat2", cyc - acc2, 2);
      check("b2b_res2", result, 4'b0101);

      // Reset during the second shift cycle.
      @(posedge clk); #2;
      cmd_valid = 1'b1; cmd_data = 4'b1010; cmd_nshift = 3'd4; cmd_fill = 1'b0;
      @(negedge clk);
      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #2; cmd_valid = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #2; rst = 1'b1;
      @(negedge clk);
      check("mid_shift_en", sr_shift_en, 1'b1);
      @(posedge clk); #2; rst = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_result", result, 4'h0);
      repeat (6) @(negedge clk);

`ifdef SHIFTREG_SEQ_ABORT_EN
      run_cmd(4'b0110, 3'd0, 1'b0, 4'b0110, 2);
      @(posedge clk); #2;
      cmd_valid = 1'b1; cmd_data = 4'b1010; cmd_nshift = 3'd4; cmd_fill = 1'b0;
      @(negedge clk);
      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #2; cmd_valid = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #2; abort = 1'b1;
      @(posedge clk); #2; abort = 1'b0;
      @(negedge clk);
      check("abort_pulse", aborted, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_result", result, 4'b0110);
      repeat (6) @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
